// File: rtl/common_p.sv
// rtl/common_p.sv - shared clock-domain bundle and counter boundary-policy types
package common_p;

   typedef struct packed {
      logic clk;
      logic sync_rst;
      logic clk_en;
   } clk_dom_s;

   // Encoding 2'd3 is not named; lanes fall back to SATURATE for it.
   typedef enum logic [1:0] {
      WRAP     = 2'd0,
      SATURATE = 2'd1,
      RELOAD   = 2'd2
   } count_mode_e;

endpackage

// File: rtl/bounded_counter_lane.sv
// rtl/bounded_counter_lane.sv - one bounded up/down counter lane with boundary policy
module bounded_counter_lane
   import common_p::*;
#(
   parameter int BIT_WIDTH = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clk_en,
   input  logic                 i_counter_en,
   input  logic                 i_init_en,
   input  logic                 i_decay_en,
   input  logic                 i_clear_en,
   input  logic [BIT_WIDTH-1:0] i_seed,
   input  logic [BIT_WIDTH-1:0] i_growth,
   input  logic [BIT_WIDTH-1:0] i_decay,
   input  logic [BIT_WIDTH-1:0] i_upper,
   input  logic [BIT_WIDTH-1:0] i_lower,
   input  count_mode_e          i_mode,
   output logic [BIT_WIDTH-1:0] o_count,
   output logic                 o_overflow,
   output logic                 o_underflow,
   output logic                 o_at_upper,
   output logic                 o_at_lower
);

   localparam int W = BIT_WIDTH;
   localparam logic signed [W+1:0] ONE = (W+2)'(1);

   logic [W-1:0]        r_count;
   logic                r_ovf;
   logic                r_udf;

   logic [W-1:0]        w_next;
   logic                w_ovf;
   logic                w_udf;
   logic                w_update;
   logic [W:0]          w_sum;
   logic signed [W+1:0] w_diff;
   logic signed [W+1:0] w_upper_s;
   logic signed [W+1:0] w_lower_s;
   logic signed [W+1:0] w_wrap_up;
   logic signed [W+1:0] w_wrap_dn;

   assign w_update = i_clk_en && (i_counter_en || i_clear_en);

   // Arithmetic is widened so neither the carry nor a borrow below zero is lost.
   always_comb begin
      w_sum     = {1'b0, r_count} + {1'b0, i_growth};
      w_diff    = signed'({2'b00, r_count}) - signed'({2'b00, i_decay});
      w_upper_s = signed'({2'b00, i_upper});
      w_lower_s = signed'({2'b00, i_lower});
      w_wrap_up = w_lower_s + (signed'({1'b0, w_sum}) - w_upper_s - ONE);
      w_wrap_dn = w_upper_s - (w_lower_s - w_diff - ONE);
   end

   always_comb begin
      w_next = r_count;
      w_ovf  = 1'b0;
      w_udf  = 1'b0;
      if (i_clear_en) begin
         w_next = '0;
      end else if (i_init_en) begin
         w_next = i_seed;
      end else if (i_lower > i_upper) begin
         w_next = i_lower;
      end else if (i_decay_en) begin
         if ((i_decay != '0) && (w_diff < w_lower_s)) begin
            w_udf = 1'b1;
            case (i_mode)
               WRAP:    w_next = (w_wrap_dn < w_lower_s) ? i_upper : w_wrap_dn[W-1:0];
               RELOAD:  w_next = i_seed;
               default: w_next = i_lower;
            endcase
         end else begin
            w_next = w_diff[W-1:0];
         end
      end else begin
         if ((i_growth != '0) && (w_sum > {1'b0, i_upper})) begin
            w_ovf = 1'b1;
            case (i_mode)
               WRAP:    w_next = (w_wrap_up > w_upper_s) ? i_lower : w_wrap_up[W-1:0];
               RELOAD:  w_next = i_seed;
               default: w_next = i_upper;
            endcase
         end else begin
            w_next = w_sum[W-1:0];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else if (w_update) begin
         r_count <= w_next;
         r_ovf   <= w_ovf;
         r_udf   <= w_udf;
      end else begin
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end
   end

   assign o_count     = r_count;
   assign o_overflow  = r_ovf;
   assign o_underflow = r_udf;
   assign o_at_upper  = (r_count == i_upper);
   assign o_at_lower  = (r_count == i_lower);

endmodule

// File: rtl/bounded_counter.sv
// rtl/bounded_counter.sv - array of independent bounded counter lanes
module bounded_counter
   import common_p::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int CHANNELS  = 1
) (
   input  clk_dom_s                              sys_dom_i,
   input  logic        [CHANNELS-1:0]                 counter_en_i,
   input  logic        [CHANNELS-1:0]                 init_en_i,
   input  logic        [CHANNELS-1:0]                 decay_en_i,
   input  logic        [CHANNELS-1:0]                 clear_en_i,
   input  logic        [CHANNELS-1:0][BIT_WIDTH-1:0]  seed_i,
   input  logic        [CHANNELS-1:0][BIT_WIDTH-1:0]  growth_rate_i,
   input  logic        [CHANNELS-1:0][BIT_WIDTH-1:0]  decay_rate_i,
   input  logic        [CHANNELS-1:0][BIT_WIDTH-1:0]  upper_bound_i,
   input  logic        [CHANNELS-1:0][BIT_WIDTH-1:0]  lower_bound_i,
   input  count_mode_e [CHANNELS-1:0]                 mode_i,
   output logic        [CHANNELS-1:0][BIT_WIDTH-1:0]  count_o,
   output logic        [CHANNELS-1:0]                 overflow_o,
   output logic        [CHANNELS-1:0]                 underflow_o,
   output logic        [CHANNELS-1:0]                 at_upper_o,
   output logic        [CHANNELS-1:0]                 at_lower_o
);

   for (genvar n = 0; n < CHANNELS; n++) begin : g_lane
      bounded_counter_lane #(
         .BIT_WIDTH (BIT_WIDTH)
      ) u_lane (
         .i_clk        (sys_dom_i.clk),
         .i_rst        (sys_dom_i.sync_rst),
         .i_clk_en     (sys_dom_i.clk_en),
         .i_counter_en (counter_en_i[n]),
         .i_init_en    (init_en_i[n]),
         .i_decay_en   (decay_en_i[n]),
         .i_clear_en   (clear_en_i[n]),
         .i_seed       (seed_i[n]),
         .i_growth     (growth_rate_i[n]),
         .i_decay      (decay_rate_i[n]),
         .i_upper      (upper_bound_i[n]),
         .i_lower      (lower_bound_i[n]),
         .i_mode       (mode_i[n]),
         .o_count      (count_o[n]),
         .o_overflow   (overflow_o[n]),
         .o_underflow  (underflow_o[n]),
         .o_at_upper   (at_upper_o[n]),
         .o_at_lower   (at_lower_o[n])
      );
   end

endmodule

// File: tb/tb_bounded_counter.sv
// tb/tb_bounded_counter.sv - scoreboard bench for a four-lane bounded_counter
module tb_bounded_counter;
   import common_p::*;

   localparam int W = 8;
   localparam int C = 4;

   logic clk = 1'b0;
   logic rst;
   logic clk_en;
   clk_dom_s sys_dom;

   logic        [C-1:0]        counter_en, init_en, decay_en, clear_en;
   logic        [C-1:0][W-1:0] seed, growth, decay, upper, lower;
   count_mode_e [C-1:0]        mode;
   logic        [C-1:0][W-1:0] count;
   logic        [C-1:0]        ovf, udf, atu, atl;

   typedef struct {
      string       nm;
      logic [31:0] c;
      logic [3:0]  o, u, au, al;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;
   assign sys_dom = {clk, rst, clk_en};

   bounded_counter #(.BIT_WIDTH(W), .CHANNELS(C)) dut (
      .sys_dom_i     (sys_dom),
      .counter_en_i  (counter_en),
      .init_en_i     (init_en),
      .decay_en_i    (decay_en),
      .clear_en_i    (clear_en),
      .seed_i        (seed),
      .growth_rate_i (growth),
      .decay_rate_i  (decay),
      .upper_bound_i (upper),
      .lower_bound_i (lower),
      .mode_i        (mode),
      .count_o       (count),
      .overflow_o    (ovf),
      .underflow_o   (udf),
      .at_upper_o    (atu),
      .at_lower_o    (atl)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every cycle a result is outstanding, pop it and compare after the edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({e.nm, "/count"},    count, e.c);
         chk({e.nm, "/overflow"}, {28'd0, ovf}, {28'd0, e.o});
         chk({e.nm, "/underflow"},{28'd0, udf}, {28'd0, e.u});
         chk({e.nm, "/at_upper"}, {28'd0, atu}, {28'd0, e.au});
         chk({e.nm, "/at_lower"}, {28'd0, atl}, {28'd0, e.al});
      end
   end

   task automatic push(input string nm, input logic [31:0] c,
                       input logic [3:0] o, input logic [3:0] u,
                       input logic [3:0] au, input logic [3:0] al);
      exp_t e;
      e.nm = nm; e.c = c; e.o = o; e.u = u; e.au = au; e.al = al;
      q.push_back(e);
      @(negedge clk);
   endtask

   // Single-lane step: idle lanes 1..3 stay at 0 inside [0,255].
   task automatic exp0(input string nm, input logic [7:0] c0, input logic o0,
                       input logic u0, input logic au0, input logic al0);
      push(nm, {24'd0, c0}, {3'b000, o0}, {3'b000, u0}, {3'b000, au0}, {3'b111, al0});
   endtask

   task automatic set0(input logic ce, input logic ie, input logic de, input logic cl,
                       input logic [7:0] sd, input logic [7:0] gr, input logic [7:0] dr,
                       input logic [7:0] up, input logic [7:0] lo, input count_mode_e md);
      counter_en[0] = ce; init_en[0] = ie; decay_en[0] = de; clear_en[0] = cl;
      seed[0] = sd; growth[0] = gr; decay[0] = dr;
      upper[0] = up; lower[0] = lo; mode[0] = md;
   endtask

   initial begin
      counter_en = '0; init_en = '0; decay_en = '0; clear_en = '0;
      seed = '0; growth = '0; decay = '0; lower = '0;
      for (int i = 0; i < C; i++) begin
         upper[i] = 8'd255;
         mode[i]  = SATURATE;
      end

      rst = 1'b1; clk_en = 1'b0;
      set0(1, 0, 0, 0, 18, 5, 0, 20, 10, WRAP);         exp0("reset", 0, 0, 0, 0, 0);
      rst = 1'b0; clk_en = 1'b1;
      set0(1, 1, 0, 0, 18, 5, 0, 20, 10, WRAP);         exp0("wrap_init", 18, 0, 0, 0, 0);
      set0(1, 0, 0, 0, 18, 5, 0, 20, 10, WRAP);         exp0("wrap_ovf", 12, 1, 0, 0, 0);
      set0(0, 0, 0, 0, 18, 5, 0, 20, 10, WRAP);         exp0("wrap_hold", 12, 0, 0, 0, 0);
      set0(1, 1, 0, 0, 250, 10, 0, 255, 0, SATURATE);   exp0("sat_init", 250, 0, 0, 0, 0);
      set0(1, 0, 0, 0, 250, 10, 0, 255, 0, SATURATE);   exp0("sat_ovf1", 255, 1, 0, 1, 0);
      set0(1, 0, 0, 0, 250, 10, 0, 255, 0, SATURATE);   exp0("sat_ovf2", 255, 1, 0, 1, 0);
      set0(0, 0, 0, 0, 250, 10, 0, 255, 0, SATURATE);   exp0("sat_hold", 255, 0, 0, 1, 0);
      set0(1, 1, 0, 0, 6, 0, 3, 50, 5, RELOAD);         exp0("rld_init", 6, 0, 0, 0, 0);
      set0(1, 0, 1, 0, 7, 0, 3, 50, 5, RELOAD);         exp0("rld_udf", 7, 0, 1, 0, 0);
      set0(0, 0, 1, 0, 7, 0, 3, 50, 5, RELOAD);         exp0("rld_hold", 7, 0, 0, 0, 0);
      set0(1, 1, 0, 0, 30, 0, 3, 50, 5, RELOAD);        exp0("pri_init", 30, 0, 0, 0, 0);
      set0(1, 1, 1, 1, 30, 0, 3, 50, 5, RELOAD);        exp0("pri_clear", 0, 0, 0, 0, 0);
      set0(1, 1, 0, 0, 30, 0, 3, 50, 5, RELOAD);        exp0("pri_reinit", 30, 0, 0, 0, 0);
      clk_en = 1'b0;
      set0(1, 1, 1, 1, 30, 0, 3, 50, 5, RELOAD);        exp0("clken_off", 30, 0, 0, 0, 0);
      clk_en = 1'b1;
      set0(1, 1, 0, 0, 18, 5, 0, 20, 10, WRAP);         exp0("rst_pre", 18, 0, 0, 0, 0);
      rst = 1'b1;
      set0(1, 0, 0, 0, 18, 5, 0, 20, 10, WRAP);         exp0("rst_mid", 0, 0, 0, 0, 0);
      rst = 1'b0;
      set0(1, 1, 0, 0, 18, 5, 0, 20, 10, WRAP);         exp0("rst_resume_init", 18, 0, 0, 0, 0);
      set0(1, 0, 0, 0, 18, 5, 0, 20, 10, WRAP);         exp0("rst_resume_ovf", 12, 1, 0, 0, 0);
      set0(1, 0, 0, 0, 18, 0, 0, 20, 10, WRAP);         exp0("rate_zero", 12, 0, 0, 0, 0);
      set0(1, 0, 0, 0, 18, 1, 0, 5, 9, WRAP);           exp0("inverted", 9, 0, 0, 0, 1);
      set0(1, 1, 0, 0, 11, 0, 4, 20, 10, WRAP);         exp0("wud_init", 11, 0, 0, 0, 0);
      set0(1, 0, 1, 0, 11, 0, 4, 20, 10, WRAP);         exp0("wrap_udf", 18, 0, 1, 0, 0);
      set0(1, 0, 1, 0, 11, 0, 4, 20, 10, SATURATE);     exp0("sat_dec", 14, 0, 0, 0, 0);
      set0(1, 0, 1, 0, 11, 0, 10, 20, 10, SATURATE);    exp0("sat_udf", 10, 0, 1, 0, 1);
      set0(0, 0, 0, 1, 11, 0, 10, 20, 10, SATURATE);    exp0("clear_only", 0, 0, 0, 0, 0);

      // Four lanes in the same cycles: grow, decay, init, disabled.
      set0(1, 1, 0, 0, 18, 5, 0, 20, 10, WRAP);
      counter_en[1] = 1'b1; init_en[1] = 1'b1; seed[1] = 8'd6; decay[1] = 8'd3;
      upper[1] = 8'd50; lower[1] = 8'd5; mode[1] = RELOAD;
      counter_en[3] = 1'b1; init_en[3] = 1'b1; seed[3] = 8'd100; growth[3] = 8'd9;
      push("multi_init", {8'd100, 8'd0, 8'd6, 8'd18}, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
      init_en[0] = 1'b0;
      init_en[1] = 1'b0; decay_en[1] = 1'b1; seed[1] = 8'd7;
      counter_en[2] = 1'b1; init_en[2] = 1'b1; seed[2] = 8'd42;
      counter_en[3] = 1'b0; init_en[3] = 1'b0;
      push("multi_op", {8'd100, 8'd42, 8'd7, 8'd12}, 4'b0001, 4'b0010, 4'b0000, 4'b0000);
      counter_en = '0; init_en = '0; decay_en = '0;
      push("multi_hold", {8'd100, 8'd42, 8'd7, 8'd12}, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d results still pending, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/bounded_counter.md
BOUNDED_COUNTER -- requirements
Module: bounded_counter

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8: width of every count, rate, seed and bound.
REQ-002 SHALL have parameter CHANNELS, default 1: number of independent counter lanes.
REQ-003 SHALL take sys_dom_i.clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL take sys_dom_i.sync_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL take sys_dom_i.clk_en  input  1  clock enable qualifying every non-reset update.
REQ-006 SHALL take sys_dom_i as a common_p::clk_dom_s bundle carrying clk, sync_rst and clk_en.
REQ-007 SHALL take the following per-lane inputs, each packed [CHANNELS-1:0]:
- counter_en_i  1: update enable.
- init_en_i  1: load seed.
- decay_en_i  1: subtract instead of add.
- clear_en_i  1: force zero.
REQ-008 SHALL take seed_i, growth_rate_i, decay_rate_i, upper_bound_i and lower_bound_i, each input  [CHANNELS-1:0][BIT_WIDTH-1:0]  per-lane value.
REQ-009 SHALL take mode_i  input  [CHANNELS-1:0] of common_p::count_mode_e  boundary policy: WRAP, SATURATE or RELOAD.
REQ-010 SHALL drive count_o  output  [CHANNELS-1:0][BIT_WIDTH-1:0]  registered count.
REQ-011 SHALL drive overflow_o and underflow_o  output  [CHANNELS-1:0]  one-cycle boundary-crossing pulses.
REQ-012 SHALL drive at_upper_o and at_lower_o  output  [CHANNELS-1:0]  level flags for count == upper and count == lower.

Function
REQ-013 SHALL update lane n only when sync_rst, or clk_en && (counter_en_i[n] || clear_en_i[n]); otherwise the lane holds its count and its pulses go low.
REQ-014 SHALL resolve operations in the priority sync_rst > clear > init > decay > grow.
REQ-015 SHALL make count_o change on the edge after a qualifying cycle (latency 1); pulses SHALL be registered alongside the count.
REQ-016 SHALL set clear: count = 0, no pulses, independent of bounds.
REQ-017 SHALL set init: count = seed, no pulses, even if seed lies outside [lower, upper].
REQ-018 SHALL compute grow as sum = count + growth in BIT_WIDTH+1 bits; sum > upper SHALL raise overflow.
REQ-019 SHALL compute decay as diff = count - decay in signed BIT_WIDTH+2 bits; diff < lower SHALL raise underflow.
REQ-020 SHALL apply these overflow results:
- WRAP: lower + (sum - upper - 1), clamped to lower if still > upper.
- SATURATE: upper.
- RELOAD: seed.
REQ-021 SHALL apply these underflow results:
- WRAP: upper - (lower - diff - 1), clamped to upper if still < lower.
- SATURATE: lower.
- RELOAD: seed.
REQ-022 SHALL pulse overflow_o/underflow_o for exactly one cycle per crossing, including under SATURATE while already pinned.
REQ-023 SHALL treat a rate of 0 as a legal hold: no crossing, no pulse.
REQ-024 SHALL, when lower > upper on a grow/decay cycle, set count = lower and suppress pulses.
REQ-025 SHALL keep lanes fully independent; simultaneous operations on different lanes SHALL not interact.
REQ-026 SHALL derive at_upper_o and at_lower_o combinationally from registered count and current bounds.

Reset
REQ-027 SHALL clear every count_o to 0 and overflow_o/underflow_o to 0 on sync_rst, regardless of clk_en.
REQ-028 SHALL let sync_rst asserted mid-operation override any pending operation in that cycle, with no pulse emitted.

Structure
REQ-029 SHALL define count_mode_e (WRAP=2'd0, SATURATE=2'd1, RELOAD=2'd2; 2'd3 treated as SATURATE) in common_p, beside clk_dom_s.
REQ-030 SHALL implement one lane as sub-module bounded_counter_lane, instantiated CHANNELS times by a generate loop.

Verification
REQ-031 SHALL cover WRAP, W=8, [10,20], count 18, grow 5 -> count 12, overflow_o one cycle.
REQ-032 SHALL cover SATURATE, [0,255], count 250, grow 10 twice -> 255 both times, two overflow pulses, at_upper_o high.
REQ-033 SHALL cover RELOAD, seed 7, [5,50], count 6, decay 3 -> count 7, underflow_o one cycle.
REQ-034 SHALL cover a lane with clear, init and decay all asserted with clk_en=1 -> count 0, no pulse; with clk_en=0 -> count unchanged.
REQ-035 SHALL cover sync_rst asserted while a lane would overflow -> count 0, no pulse, then normal resumption.
REQ-036 SHALL cover CHANNELS=4, with lane 0 growing, lane 1 decaying, lane 2 initialising and lane 3 disabled, all in the same cycle -> each lane matches its single-lane result.
